// File: rtl/seq_checker.sv
// seq_checker
// Serial pattern checker placed downstream of the 8-bit sequence generator.
// It hunts for frame alignment in the serial stream, qualifies lock over
// LOCK_N consecutive clean frames, then monitors the locked stream. It reports
// bit errors, good frames and loss of lock.
//
// Ports:
//   clk       - clock, rising edge
//   clrn      - asynchronous active-low reset
//   en        - sample enable; din is consumed only when en=1
//   din       - serial data, pattern bit 0 first
//   pattern   - expected 8-bit frame, sampled live
//   match     - one-cycle pulse: a correct 8-bit frame just completed
//   locked    - high while in LOCK
//   bit_err   - one-cycle pulse: sampled bit mismatched (CHECK or LOCK)
//   err_cnt   - saturating count of mismatched bits seen in LOCK
//   match_cnt - saturating count of match pulses
//   phase     - expected bit index of the next sample
module seq_checker #(
  parameter int LOCK_N = 2,
  parameter int LOSS_N = 2,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          en,
  input  logic          din,
  input  logic [7:0]    pattern,
  output logic          match,
  output logic          locked,
  output logic          bit_err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] match_cnt,
  output logic [2:0]    phase
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  localparam logic [2:0] LOCK_N3 = 3'(LOCK_N);
  localparam logic [2:0] LOSS_N3 = 3'(LOSS_N);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  state_t        state_q, state_d;
  // The oldest of the 8 history bits drops out of the window on the very
  // edge it would be used, so only the newest 7 bits need storage.
  logic [6:0]    sr_q, sr_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    good_run_q, good_run_d;
  logic [2:0]    bad_run_q, bad_run_d;
  logic          frame_err_q, frame_err_d;
  logic          match_q, match_d;
  logic          bit_err_q, bit_err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;

  logic [7:0]    w;
  logic          bit_ok;
  logic          last_bit;
  logic          frame_bad;
  logic [2:0]    phase_inc;
  logic [2:0]    good_run_inc;
  logic [2:0]    bad_run_inc;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    phase_d      = phase_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    frame_err_d  = frame_err_q;
    match_d      = 1'b0;
    bit_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    match_cnt_d  = match_cnt_q;

    // Window includes the bit being sampled on this edge.
    w            = {din, sr_q};
    bit_ok       = (din == pattern[phase_q]);
    last_bit     = (phase_q == 3'd7);
    phase_inc    = phase_q + 3'd1;
    good_run_inc = good_run_q + 3'd1;
    bad_run_inc  = bad_run_q + 3'd1;
    // In LOCK, an errored phase-7 bit both counts and closes the frame as bad.
    frame_bad    = frame_err_q | ~bit_ok;

    if (en) begin
      sr_d = w[7:1];
      case (state_q)
        HUNT: begin
          phase_d = 3'd0;
          if (w == pattern) begin
            state_d     = CHECK;
            good_run_d  = 3'd0;
            match_d     = 1'b1;
            match_cnt_d = sat_inc(match_cnt_q);
          end
        end
        CHECK: begin
          if (!bit_ok) begin
            bit_err_d = 1'b1;
            state_d   = HUNT;
            phase_d   = 3'd0;
          end else begin
            phase_d = phase_inc;
            if (last_bit) begin
              match_d     = 1'b1;
              match_cnt_d = sat_inc(match_cnt_q);
              good_run_d  = good_run_inc;
              if (good_run_inc == LOCK_N3) begin
                state_d   = LOCK;
                bad_run_d = 3'd0;
              end
            end
          end
        end
        LOCK: begin
          phase_d = phase_inc;
          if (!bit_ok) begin
            bit_err_d = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
          end
          if (last_bit) begin
            frame_err_d = 1'b0;
            if (frame_bad) begin
              bad_run_d = bad_run_inc;
              if (bad_run_inc == LOSS_N3) begin
                state_d = HUNT;
                phase_d = 3'd0;
              end
            end else begin
              bad_run_d   = 3'd0;
              match_d     = 1'b1;
              match_cnt_d = sat_inc(match_cnt_q);
            end
          end else begin
            frame_err_d = frame_bad;
          end
        end
        default: begin
          state_d = HUNT;
          phase_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      phase_q     <= '0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      frame_err_q <= 1'b0;
      match_q     <= 1'b0;
      bit_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      phase_q     <= phase_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      frame_err_q <= frame_err_d;
      match_q     <= match_d;
      bit_err_q   <= bit_err_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match     = match_q;
  assign bit_err   = bit_err_q;
  assign locked    = (state_q == LOCK);
  assign err_cnt   = err_cnt_q;
  assign match_cnt = match_cnt_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;

  logic       clk;
  logic       clrn;
  logic       en;
  logic       din;
  logic [7:0] pattern;
  logic       match, locked, bit_err;
  logic [7:0] err_cnt, match_cnt;
  logic [2:0] phase;
  logic       match7, locked7, bit_err7;
  logic [7:0] err_cnt7, match_cnt7;
  logic [2:0] phase7;

  int checks   = 0;
  int failures = 0;

  seq_checker #(.LOCK_N(2), .LOSS_N(2), .CW(8)) u_dut (
    .clk(clk), .clrn(clrn), .en(en), .din(din), .pattern(pattern),
    .match(match), .locked(locked), .bit_err(bit_err),
    .err_cnt(err_cnt), .match_cnt(match_cnt), .phase(phase)
  );

  seq_checker #(.LOCK_N(2), .LOSS_N(7), .CW(8)) u_dut7 (
    .clk(clk), .clrn(clrn), .en(en), .din(din), .pattern(pattern),
    .match(match7), .locked(locked7), .bit_err(bit_err7),
    .err_cnt(err_cnt7), .match_cnt(match_cnt7), .phase(phase7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic send_bit(input logic b, input logic e);
    en  = e;
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] f, output logic [7:0] mm, output logic [7:0] bm);
    for (int i = 0; i < 8; i++) begin
      send_bit(f[i], 1'b1);
      mm[i] = match;
      bm[i] = bit_err;
    end
    en = 1'b0;
  endtask

  task automatic do_reset();
    en   = 1'b0;
    din  = 1'b0;
    clrn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  task automatic lock_up(output logic [7:0] mm_all, output logic [7:0] bm_all);
    logic [7:0] mm, bm;
    mm_all = 8'h00;
    bm_all = 8'h00;
    for (int k = 0; k < 3; k++) begin
      send_frame(8'hB2, mm, bm);
      mm_all = mm_all | mm;
      bm_all = bm_all | bm;
    end
  endtask

  task automatic test_reset();
    en = 1'b0; din = 1'b0; pattern = 8'hB2; clrn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({match, locked, bit_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {match, locked, bit_err}); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_match_cnt got %0d want 0", match_cnt); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got %0d want 0", phase); end
    clrn = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] mm, bm;
    do_reset();
    pattern = 8'hB2;
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL lock_hit_match got %h want 80", mm); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_f1_locked got %b want 0", locked); end
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL lock_f2_match got %h want 80", mm); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_f2_locked got %b want 0", locked); end
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL lock_f3_match got %h want 80", mm); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_f3_locked got %b want 1", locked); end
    checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL lock_match_cnt got %0d want 3", match_cnt); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL lock_err_cnt got %0d want 0", err_cnt); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL lock_phase got %0d want 0", phase); end
  endtask

  // Continues from the locked state left by test_lock (frames 4..6).
  task automatic test_single_err();
    logic [7:0] mm, bm;
    send_frame(8'hB2, mm, bm);
    send_frame(8'hBA, mm, bm);
    checks++; if (bm !== 8'h08) begin failures++; $display("FAIL serr_bit_err got %h want 08", bm); end
    checks++; if (mm !== 8'h00) begin failures++; $display("FAIL serr_match got %h want 00", mm); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL serr_err_cnt got %0d want 1", err_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL serr_locked got %b want 1", locked); end
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL serr_recover_match got %h want 80", mm); end
    checks++; if (match_cnt !== 8'd5) begin failures++; $display("FAIL serr_match_cnt got %0d want 5", match_cnt); end
  endtask

  // Continues from the locked state left by test_single_err.
  task automatic test_loss();
    logic [7:0] mm, bm;
    send_frame(8'hB3, mm, bm);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL loss_first_bad_locked got %b want 1", locked); end
    checks++; if (bm !== 8'h01) begin failures++; $display("FAIL loss_first_bad_bit_err got %h want 01", bm); end
    send_frame(8'hB3, mm, bm);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_drop_locked got %b want 0", locked); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL loss_drop_phase got %0d want 0", phase); end
    checks++; if (err_cnt !== 8'd3) begin failures++; $display("FAIL loss_err_cnt got %0d want 3", err_cnt); end
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL loss_rehunt_match got %h want 80", mm); end
    send_frame(8'hB2, mm, bm);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_relock_early got %b want 0", locked); end
    send_frame(8'hB2, mm, bm);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL loss_relock got %b want 1", locked); end
  endtask

  task automatic test_check_err();
    logic [7:0] mm, bm;
    do_reset();
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL chk_hit got %h want 80", mm); end
    send_frame(8'hB6, mm, bm);
    checks++; if (bm !== 8'h04) begin failures++; $display("FAIL chk_bit_err got %h want 04", bm); end
    checks++; if (mm !== 8'h00) begin failures++; $display("FAIL chk_match got %h want 00", mm); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL chk_err_cnt got %0d want 0", err_cnt); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL chk_phase got %0d want 0", phase); end
    send_frame(8'hB2, mm, bm);
    checks++; if (mm !== 8'h80) begin failures++; $display("FAIL chk_rehit got %h want 80", mm); end
    checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL chk_match_cnt got %0d want 2", match_cnt); end
  endtask

  task automatic test_en_gap();
    logic [7:0] mm, bm, mm2, bm2;
    do_reset();
    lock_up(mm, bm);
    for (int i = 0; i < 3; i++) send_bit(pattern[i], 1'b1);
    checks++; if (phase !== 3'd3) begin failures++; $display("FAIL gap_phase_pre got %0d want 3", phase); end
    for (int i = 0; i < 5; i++) begin
      send_bit(i[0], 1'b0);
      checks++; if ({phase, bit_err, match} !== {3'd3, 2'b00}) begin failures++; $display("FAIL gap_frozen cyc %0d got %b want 01100", i, {phase, bit_err, match}); end
    end
    checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL gap_match_cnt got %0d want 3", match_cnt); end
    mm = 8'h00; bm = 8'h00;
    for (int i = 3; i < 8; i++) begin
      send_bit(pattern[i], 1'b1);
      mm[i] = match;
      bm[i] = bit_err;
    end
    send_frame(8'hB2, mm2, bm2);
    checks++; if ({mm, bm2 | bm} !== {8'h80, 8'h00}) begin failures++; $display("FAIL gap_resume got %h want 8000", {mm, bm2 | bm}); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_locked got %b want 1", locked); end
    checks++; if (match_cnt !== 8'd5) begin failures++; $display("FAIL gap_match_cnt_end got %0d want 5", match_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mm, bm;
    do_reset();
    lock_up(mm, bm);
    for (int i = 0; i < 3; i++) send_bit(pattern[i], 1'b1);
    #2;
    clrn = 1'b0;
    #1;
    checks++; if ({match, locked, bit_err, phase} !== 6'd0) begin failures++; $display("FAIL rmid_flags got %b want 0", {match, locked, bit_err, phase}); end
    checks++; if ({err_cnt, match_cnt} !== 16'd0) begin failures++; $display("FAIL rmid_counts got %h want 0", {err_cnt, match_cnt}); end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    lock_up(mm, bm);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rmid_relock got %b want 1", locked); end
    checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL rmid_match_cnt got %0d want 3", match_cnt); end
  endtask

  task automatic test_saturation();
    logic [7:0] mm, bm;
    do_reset();
    lock_up(mm, bm);
    for (int i = 0; i < 38; i++) begin
      send_frame(8'h4D, mm, bm);
      send_frame(8'hB2, mm, bm);
      if (i == 30) begin
        checks++; if (err_cnt7 !== 8'd248) begin failures++; $display("FAIL sat_pre got %0d want 248", err_cnt7); end
      end
      if (i == 31) begin
        checks++; if (err_cnt7 !== 8'd255) begin failures++; $display("FAIL sat_edge got %0d want 255", err_cnt7); end
      end
    end
    checks++; if (err_cnt7 !== 8'd255) begin failures++; $display("FAIL sat_err_cnt7 got %0d want 255", err_cnt7); end
    checks++; if (locked7 !== 1'b1) begin failures++; $display("FAIL sat_locked7 got %b want 1", locked7); end
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got %0d want 255", err_cnt); end
    checks++; if (match_cnt7 !== 8'd41) begin failures++; $display("FAIL sat_match_cnt7 got %0d want 41", match_cnt7); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_loss();
    test_check_err();
    test_en_gap();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
